wb_stage: RTL and testbench



---
 rtl/wb_stage.sv | 217 +++++++++++++++++++++
 tb/tb_wb_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: retires MEM results and aligned loads into the register file
// Optional feature: define WB_INSTRET_EN to build the 64-bit retired-instruction counter.
module wb_stage #(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic                  clk_100MHz,
  input  logic                  rst,
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic                  mem_rd_we_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr_i,
  input  logic [XLEN-1:0]       mem_result_i,
  input  logic                  mem_is_load_i,
  input  logic [2:0]            mem_funct3_i,
  input  logic [1:0]            mem_addr_lo_i,
  input  logic                  dmem_rvalid_i,
  input  logic [XLEN-1:0]       dmem_rdata_i,
  output logic                  w_e_o,
  output logic [REG_ADDR_W-1:0] w_addr_o,
  output logic [XLEN-1:0]       w_data_o,
  output logic                  err_o,
  output logic                  err_sticky_o,
  output logic [63:0]           instret_o
);

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_LOAD_WAIT = 1'b1
  } state_e;

  // Last counter value before a pending load is abandoned.
  localparam logic [7:0] TIMEOUT_LAST = 8'(LOAD_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d;
  logic                  ld_we_q, ld_we_d;
  logic [2:0]            ld_f3_q, ld_f3_d;
  logic [1:0]            ld_lo_q, ld_lo_d;
  logic                  w_e_q, w_e_d;
  logic [REG_ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [XLEN-1:0]       w_data_q, w_data_d;
  logic                  err_q, err_d;
  logic                  sticky_q, sticky_d;
  logic                  retire_d;

  logic                  accept;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic                  ld_ok;
  logic [XLEN-1:0]       ld_val;

  assign mem_ready_o = (state_q == S_IDLE);
  assign accept      = mem_valid_i & mem_ready_o;

  // Select the addressed byte/half of the response word and extend it per the captured load type.
  always_comb begin
    ld_byte = 8'h00;
    case (ld_lo_q)
      2'd0:    ld_byte = dmem_rdata_i[7:0];
      2'd1:    ld_byte = dmem_rdata_i[15:8];
      2'd2:    ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    ld_half = ld_lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    ld_ok   = 1'b0;
    ld_val  = '0;
    case (ld_f3_q)
      3'b000: begin
        ld_ok  = 1'b1;
        ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      end
      3'b001: begin
        ld_ok  = ~ld_lo_q[0];
        ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
      end
      3'b010: begin
        ld_ok  = (ld_lo_q == 2'd0);
        ld_val = dmem_rdata_i;
      end
      3'b100: begin
        ld_ok  = 1'b1;
        ld_val = {{(XLEN-8){1'b0}}, ld_byte};
      end
      3'b101: begin
        ld_ok  = ~ld_lo_q[0];
        ld_val = {{(XLEN-16){1'b0}}, ld_half};
      end
      default: begin
        ld_ok  = 1'b0;
        ld_val = '0;
      end
    endcase
  end

  // Next-state and write-port decisions; write address/data only move when a write is issued.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_rd_d  = ld_rd_q;
    ld_we_d  = ld_we_q;
    ld_f3_d  = ld_f3_q;
    ld_lo_d  = ld_lo_q;
    w_e_d    = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    err_d    = 1'b0;
    retire_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A response with no load outstanding is spurious; its data is dropped.
        if (dmem_rvalid_i) begin
          err_d = 1'b1;
        end
        if (accept) begin
          if (mem_is_load_i) begin
            ld_rd_d = mem_rd_addr_i;
            ld_we_d = mem_rd_we_i;
            ld_f3_d = mem_funct3_i;
            ld_lo_d = mem_addr_lo_i;
            cnt_d   = 8'd0;
            state_d = S_LOAD_WAIT;
          end else begin
            retire_d = 1'b1;
            if (mem_rd_we_i && (mem_rd_addr_i != '0)) begin
              w_e_d    = 1'b1;
              w_addr_d = mem_rd_addr_i;
              w_data_d = mem_result_i;
            end
          end
        end
      end
      S_LOAD_WAIT: begin
        // A response arriving on the timeout cycle still completes the load normally.
        if (dmem_rvalid_i) begin
          state_d = S_IDLE;
          if (ld_ok) begin
            retire_d = 1'b1;
            if (ld_we_q && (ld_rd_q != '0)) begin
              w_e_d    = 1'b1;
              w_addr_d = ld_rd_q;
              w_data_d = ld_val;
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    sticky_d = sticky_q | err_d;
  end

  // State and output registers; reset abandons any outstanding load.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      ld_rd_q  <= '0;
      ld_we_q  <= 1'b0;
      ld_f3_q  <= 3'b000;
      ld_lo_q  <= 2'd0;
      w_e_q    <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ld_rd_q  <= ld_rd_d;
      ld_we_q  <= ld_we_d;
      ld_f3_q  <= ld_f3_d;
      ld_lo_q  <= ld_lo_d;
      w_e_q    <= w_e_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign w_e_o        = w_e_q;
  assign w_addr_o     = w_addr_q;
  assign w_data_o     = w_data_q;
  assign err_o        = err_q;
  assign err_sticky_o = sticky_q;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  // Count retirements; the 64-bit counter wraps naturally.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      instret_q <= 64'd0;
    end else if (retire_d) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret_o = instret_q;
`else
  logic unused_retire;
  assign unused_retire = retire_d;
  assign instret_o     = 64'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed vector bench for wb_stage (instret checks follow WB_INSTRET_EN)
module tb_wb_stage;

  logic        clk_100MHz;
  logic        rst;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic        mem_rd_we_i;
  logic [4:0]  mem_rd_addr_i;
  logic [31:0] mem_result_i;
  logic        mem_is_load_i;
  logic [2:0]  mem_funct3_i;
  logic [1:0]  mem_addr_lo_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        w_e_o;
  logic [4:0]  w_addr_o;
  logic [31:0] w_data_o;
  logic        err_o;
  logic        err_sticky_o;
  logic [63:0] instret_o;

`ifdef WB_INSTRET_EN
  localparam bit INSTRET_ON = 1'b1;
`else
  localparam bit INSTRET_ON = 1'b0;
`endif

  wb_stage #(
    .XLEN         (32),
    .REG_ADDR_W   (5),
    .LOAD_TIMEOUT (16)
  ) dut (
    .clk_100MHz    (clk_100MHz),
    .rst           (rst),
    .mem_valid_i   (mem_valid_i),
    .mem_ready_o   (mem_ready_o),
    .mem_rd_we_i   (mem_rd_we_i),
    .mem_rd_addr_i (mem_rd_addr_i),
    .mem_result_i  (mem_result_i),
    .mem_is_load_i (mem_is_load_i),
    .mem_funct3_i  (mem_funct3_i),
    .mem_addr_lo_i (mem_addr_lo_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .w_e_o         (w_e_o),
    .w_addr_o      (w_addr_o),
    .w_data_o      (w_data_o),
    .err_o         (err_o),
    .err_sticky_o  (err_sticky_o),
    .instret_o     (instret_o)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    logic        valid;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        ld;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic        rv;
    logic [31:0] rdata;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_err;
    logic        e_sticky;
    logic        e_ready;
    logic        e_ret;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_miss;
  int   ret_cnt;

  function automatic vec_t mk(
    input logic valid, we, input logic [4:0] rd, input logic [31:0] result,
    input logic ld, input logic [2:0] f3, input logic [1:0] lo,
    input logic rv, input logic [31:0] rdata,
    input logic e_we, input logic [4:0] e_addr, input logic [31:0] e_data,
    input logic e_err, e_sticky, e_ready, e_ret);
    vec_t v;
    v.valid = valid; v.we = we; v.rd = rd; v.result = result;
    v.ld = ld; v.f3 = f3; v.lo = lo; v.rv = rv; v.rdata = rdata;
    v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data;
    v.e_err = e_err; v.e_sticky = e_sticky; v.e_ready = e_ready; v.e_ret = e_ret;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    mem_valid_i   = 1'b0;
    mem_rd_we_i   = 1'b0;
    mem_rd_addr_i = 5'd0;
    mem_result_i  = 32'd0;
    mem_is_load_i = 1'b0;
    mem_funct3_i  = 3'b000;
    mem_addr_lo_i = 2'd0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'd0;
  endtask

  task automatic drive_op(input logic we, input logic [4:0] rd, input logic [31:0] result,
                          input logic ld, input logic [2:0] f3, input logic [1:0] lo);
    mem_valid_i   = 1'b1;
    mem_rd_we_i   = we;
    mem_rd_addr_i = rd;
    mem_result_i  = result;
    mem_is_load_i = ld;
    mem_funct3_i  = f3;
    mem_addr_lo_i = lo;
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic check_instret(input string name);
    check(name, instret_o, INSTRET_ON ? 64'(ret_cnt) : 64'd0);
  endtask

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    ret_cnt = 0;

    //      valid we rd result        ld f3     lo rv rdata          e_we addr data          err stk rdy ret
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 3'b000, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 5,  32'hDEADBEEF, 0, 3'b000, 0, 0, 32'h0,        1, 5,  32'hDEADBEEF, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 3'b000, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0,  32'h11111111, 0, 3'b000, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 3,  32'h00000033, 0, 3'b000, 0, 0, 32'h0,        1, 3,  32'h00000033, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 7,  32'h00000077, 0, 3'b000, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 9,  32'h0,        1, 3'b000, 2, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 20, 32'h00000BAD, 0, 3'b000, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 3'b000, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 3'b000, 0, 1, 32'h1280FF00, 1, 9,  32'hFFFFFF80, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 10, 32'h0,        1, 3'b101, 2, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 3'b000, 0, 1, 32'h80011234, 1, 10, 32'h00008001, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 11, 32'h0,        1, 3'b001, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 3'b000, 0, 1, 32'h1234F00D, 1, 11, 32'hFFFFF00D, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 12, 32'h0,        1, 3'b100, 3, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 3'b000, 0, 1, 32'hA5000000, 1, 12, 32'h000000A5, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 13, 32'h0,        1, 3'b010, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 3'b000, 0, 1, 32'hCAFEF00D, 1, 13, 32'hCAFEF00D, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 0,  32'h0,        1, 3'b000, 1, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 3'b000, 0, 1, 32'hFFFFFFFF, 0, 0,  32'h0,        0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 14, 32'h0,        1, 3'b010, 1, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 3'b000, 0, 1, 32'h12345678, 0, 0,  32'h0,        1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 3'b000, 0, 0, 32'h0,        0, 0,  32'h0,        0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 15, 32'h0,        1, 3'b011, 0, 0, 32'h0,        0, 0,  32'h0,        0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 3'b000, 0, 1, 32'h55555555, 0, 0,  32'h0,        1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 3'b000, 0, 1, 32'h77777777, 0, 0,  32'h0,        1, 1, 1, 0));
    tbl.push_back(mk(1, 1, 4,  32'h0,        1, 3'b001, 1, 0, 32'h0,        0, 0,  32'h0,        0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 3'b000, 0, 1, 32'h0000ABCD, 0, 0,  32'h0,        1, 1, 1, 0));
    tbl.push_back(mk(1, 1, 6,  32'h00000066, 0, 3'b000, 0, 1, 32'hDEAD0000, 1, 6,  32'h00000066, 1, 1, 1, 1));
    tbl.push_back(mk(1, 1, 8,  32'h0,        1, 3'b100, 0, 1, 32'hFFFFFFFF, 0, 0,  32'h0,        1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 3'b000, 0, 1, 32'h000000C3, 1, 8,  32'h000000C3, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0,  32'h0,        0, 3'b000, 0, 0, 32'h0,        0, 0,  32'h0,        0, 1, 1, 0));

    rst = 1'b1;
    drive_idle();
    step();
    step();
    check("reset w_e", w_e_o, 0);
    check("reset w_addr", w_addr_o, 0);
    check("reset w_data", w_data_o, 0);
    check("reset err", err_o, 0);
    check("reset sticky", err_sticky_o, 0);
    check("reset instret", instret_o, 0);
    check("reset ready", mem_ready_o, 1);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      mem_valid_i   = tbl[i].valid;
      mem_rd_we_i   = tbl[i].we;
      mem_rd_addr_i = tbl[i].rd;
      mem_result_i  = tbl[i].result;
      mem_is_load_i = tbl[i].ld;
      mem_funct3_i  = tbl[i].f3;
      mem_addr_lo_i = tbl[i].lo;
      dmem_rvalid_i = tbl[i].rv;
      dmem_rdata_i  = tbl[i].rdata;
      step();
      if (tbl[i].e_ret) ret_cnt++;
      check($sformatf("v%0d w_e", i), w_e_o, tbl[i].e_we);
      if (tbl[i].e_we) begin
        check($sformatf("v%0d w_addr", i), w_addr_o, tbl[i].e_addr);
        check($sformatf("v%0d w_data", i), w_data_o, tbl[i].e_data);
      end
      check($sformatf("v%0d err", i), err_o, tbl[i].e_err);
      check($sformatf("v%0d sticky", i), err_sticky_o, tbl[i].e_sticky);
      check($sformatf("v%0d ready", i), mem_ready_o, tbl[i].e_ready);
      check_instret($sformatf("v%0d instret", i));
    end

    // Load with no response: 16 cycles in LOAD_WAIT, then err_o and back to IDLE.
    drive_idle();
    drive_op(1'b1, 5'd1, 32'h0, 1'b1, 3'b010, 2'd0);
    step();
    drive_idle();
    check("to accept ready", mem_ready_o, 0);
    for (int i = 1; i <= 15; i++) begin
      step();
      check($sformatf("to wait%0d err", i), err_o, 0);
      check($sformatf("to wait%0d ready", i), mem_ready_o, 0);
    end
    step();
    check("to expire err", err_o, 1);
    check("to expire ready", mem_ready_o, 1);
    check("to expire w_e", w_e_o, 0);
    step();
    check("to after err", err_o, 0);
    check_instret("to instret");

    // Response on the timeout cycle completes the load.
    drive_op(1'b1, 5'd2, 32'h0, 1'b1, 3'b010, 2'd0);
    step();
    drive_idle();
    for (int i = 1; i <= 15; i++) begin
      step();
    end
    check("tw wait ready", mem_ready_o, 0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h5A5AA5A5;
    step();
    drive_idle();
    ret_cnt++;
    check("tw w_e", w_e_o, 1);
    check("tw w_addr", w_addr_o, 2);
    check("tw w_data", w_data_o, 32'h5A5AA5A5);
    check("tw err", err_o, 0);
    check("tw ready", mem_ready_o, 1);
    check_instret("tw instret");

    // Reset during LOAD_WAIT abandons the load; a later response is spurious.
    drive_op(1'b1, 5'd3, 32'h0, 1'b1, 3'b010, 2'd0);
    step();
    drive_idle();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ret_cnt = 0;
    check("rw w_e", w_e_o, 0);
    check("rw w_addr", w_addr_o, 0);
    check("rw w_data", w_data_o, 0);
    check("rw err", err_o, 0);
    check("rw sticky", err_sticky_o, 0);
    check("rw instret", instret_o, 0);
    check("rw ready", mem_ready_o, 1);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h12345678;
    step();
    drive_idle();
    check("rw spurious err", err_o, 1);
    check("rw spurious sticky", err_sticky_o, 1);
    check("rw spurious w_e", w_e_o, 0);

    // Three back-to-back retirements after reset.
    for (int i = 1; i <= 3; i++) begin
      drive_op(1'b1, 5'(i), 32'(i * 16'h1111), 1'b0, 3'b000, 2'd0);
      step();
      ret_cnt++;
      check($sformatf("b2b%0d w_e", i), w_e_o, 1);
      check($sformatf("b2b%0d w_addr", i), w_addr_o, 64'(i));
      check($sformatf("b2b%0d w_data", i), w_data_o, 64'(i * 16'h1111));
    end
    drive_idle();
    step();
    check("b2b end w_e", w_e_o, 0);
    check_instret("b2b instret");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
